// File: rtl/seq_comparator_nbit.sv
// seq_comparator_nbit
//   Registered magnitude comparator with running min/max tracking of the
//   accepted 'a' samples. One sample is accepted on each rising edge where
//   in_valid is high; the result appears one cycle later with out_valid.
//
// Parameters
//   N      operand width in bits (N >= 2)
//   SIGNED 0 = unsigned compare, 1 = two's-complement compare
//   CNT_W  width of the optional acceptance counter
//
// Ports
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   clear      synchronous clear of min/max/seen (and count)
//   in_valid   qualifies a and b
//   a, b       operands; a is also the tracked sample
//   out_valid  one-cycle pulse: flags/min/max hold a fresh result
//   smaller    registered a <  b
//   equal      registered a == b
//   greater    registered a >  b
//   min_val    running minimum of accepted a
//   max_val    running maximum of accepted a
//   seen       at least one sample accepted since reset or clear
//   count      (CMP_COUNT_EN only) saturating acceptance counter
//
// Optional feature
//   Define CMP_COUNT_EN to add the 'count' output and its counter.
module seq_comparator_nbit #(
  parameter int N      = 12,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  output logic         smaller,
  output logic         equal,
  output logic         greater,
  output logic [N-1:0] min_val,
  output logic [N-1:0] max_val,
  output logic         seen
`ifdef CMP_COUNT_EN
  ,
  output logic [CNT_W-1:0] count
`endif
);

  // Flipping the MSB maps two's-complement ordering onto unsigned ordering,
  // so one unsigned comparator serves both signedness settings.
  localparam logic [N-1:0] BIAS = (SIGNED != 0) ? {1'b1, {(N-1){1'b0}}} : '0;

  logic [N-1:0] a_k;
  logic [N-1:0] b_k;
  logic [N-1:0] min_k;
  logic [N-1:0] max_k;
  logic         a_lt_b;
  logic         a_gt_b;
  logic         a_lt_min;
  logic         a_gt_max;
  logic         first;

  always_comb begin
    a_k      = a ^ BIAS;
    b_k      = b ^ BIAS;
    min_k    = min_val ^ BIAS;
    max_k    = max_val ^ BIAS;
    a_lt_b   = a_k < b_k;
    a_gt_b   = a_k > b_k;
    a_lt_min = a_k < min_k;
    a_gt_max = a_k > max_k;
    // A sample coinciding with clear is treated as the first after clear.
    first    = clear || !seen;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      smaller   <= 1'b0;
      equal     <= 1'b0;
      greater   <= 1'b0;
      min_val   <= '0;
      max_val   <= '0;
      seen      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        smaller <= a_lt_b;
        equal   <= !a_lt_b && !a_gt_b;
        greater <= a_gt_b;
        if (first) begin
          min_val <= a;
          max_val <= a;
          seen    <= 1'b1;
        end else begin
          if (a_lt_min) min_val <= a;
          if (a_gt_max) max_val <= a;
        end
      end else if (clear) begin
        min_val <= '0;
        max_val <= '0;
        seen    <= 1'b0;
      end
    end
  end

`ifdef CMP_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= {{(CNT_W-1){1'b0}}, in_valid};
    end else if (in_valid && (count != '1)) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_seq_comparator_nbit.sv
// Directed self-checking bench for seq_comparator_nbit.
// Two instances share the stimulus: u_dut (unsigned, CNT_W=3) and
// u_sdut (signed). The count checks exist only when CMP_COUNT_EN is defined.
module tb_seq_comparator_nbit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] a = '0;
  logic [11:0] b = '0;

  logic        u_ov, u_sm, u_eq, u_gt, u_seen;
  logic [11:0] u_min, u_max;
  logic        s_ov, s_sm, s_eq, s_gt, s_seen;
  logic [11:0] s_min, s_max;
`ifdef CMP_COUNT_EN
  logic [2:0]  u_count;
  logic [7:0]  s_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_comparator_nbit #(.N(12), .SIGNED(0), .CNT_W(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .a(a), .b(b), .out_valid(u_ov), .smaller(u_sm), .equal(u_eq),
    .greater(u_gt), .min_val(u_min), .max_val(u_max), .seen(u_seen)
`ifdef CMP_COUNT_EN
    , .count(u_count)
`endif
  );

  seq_comparator_nbit #(.N(12), .SIGNED(1), .CNT_W(8)) u_sdut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
    .a(a), .b(b), .out_valid(s_ov), .smaller(s_sm), .equal(s_eq),
    .greater(s_gt), .min_val(s_min), .max_val(s_max), .seen(s_seen)
`ifdef CMP_COUNT_EN
    , .count(s_count)
`endif
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    clear    = 1'b0;
    reset_n  = 1'b0;
    cyc();
    reset_n  = 1'b1;
  endtask

  // {out_valid, smaller, equal, greater, seen}
  task automatic test_reset();
    reset_n = 1'b0;
    cyc();
    cyc();
    n_cmp++;
    if ({u_ov, u_sm, u_eq, u_gt, u_seen, u_min, u_max} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset_hold_u got %b/%h/%h want 00000/000/000",
               {u_ov, u_sm, u_eq, u_gt, u_seen}, u_min, u_max);
    end
    n_cmp++;
    if ({s_ov, s_sm, s_eq, s_gt, s_seen, s_min, s_max} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset_hold_s got %b/%h/%h want 00000/000/000",
               {s_ov, s_sm, s_eq, s_gt, s_seen}, s_min, s_max);
    end
`ifdef CMP_COUNT_EN
    n_cmp++;
    if (u_count !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_count got %0d want 0", u_count);
    end
`endif
    reset_n = 1'b1;
    cyc();
    n_cmp++;
    if ({u_ov, u_sm, u_eq, u_gt, u_seen, u_min, u_max} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset_release got %b/%h/%h want 00000/000/000",
               {u_ov, u_sm, u_eq, u_gt, u_seen}, u_min, u_max);
    end
  endtask

  task automatic test_stream();
    do_reset();
    in_valid = 1'b1; a = 12'd5; b = 12'd99;
    cyc();
    n_cmp++;
    if ({u_ov, u_sm, u_eq, u_gt, u_seen} !== 5'b11001) begin
      n_bad++;
      $display("FAIL stream_smaller got %b want 11001", {u_ov, u_sm, u_eq, u_gt, u_seen});
    end
    a = 12'd66; b = 12'd66;
    cyc();
    n_cmp++;
    if ({u_ov, u_sm, u_eq, u_gt, u_seen} !== 5'b10101) begin
      n_bad++;
      $display("FAIL stream_equal got %b want 10101", {u_ov, u_sm, u_eq, u_gt, u_seen});
    end
    a = 12'd100; b = 12'd47;
    cyc();
    n_cmp++;
    if ({u_ov, u_sm, u_eq, u_gt, u_seen} !== 5'b10011) begin
      n_bad++;
      $display("FAIL stream_greater got %b want 10011", {u_ov, u_sm, u_eq, u_gt, u_seen});
    end
    n_cmp++;
    if (u_min !== 12'd5 || u_max !== 12'd100) begin
      n_bad++;
      $display("FAIL stream_minmax got %0d/%0d want 5/100", u_min, u_max);
    end
    in_valid = 1'b0;
    cyc();
    n_cmp++;
    if ({u_ov, u_sm, u_eq, u_gt} !== 4'b0001) begin
      n_bad++;
      $display("FAIL stream_end got %b want 0001", {u_ov, u_sm, u_eq, u_gt});
    end
  endtask

  task automatic test_signed();
    do_reset();
    in_valid = 1'b1; a = 12'hFFF; b = 12'd1;
    cyc();
    n_cmp++;
    if ({s_ov, s_sm, s_eq, s_gt} !== 4'b1100) begin
      n_bad++;
      $display("FAIL signed_smaller got %b want 1100", {s_ov, s_sm, s_eq, s_gt});
    end
    n_cmp++;
    if ({u_ov, u_sm, u_eq, u_gt} !== 4'b1001) begin
      n_bad++;
      $display("FAIL unsigned_greater got %b want 1001", {u_ov, u_sm, u_eq, u_gt});
    end
    a = 12'h800; b = 12'd0;
    cyc();
    n_cmp++;
    if (s_min !== 12'h800 || s_max !== 12'hFFF) begin
      n_bad++;
      $display("FAIL signed_minmax got %h/%h want 800/fff", s_min, s_max);
    end
    a = 12'd1;
    cyc();
    n_cmp++;
    if (s_min !== 12'h800 || s_max !== 12'h001) begin
      n_bad++;
      $display("FAIL signed_newmax got %h/%h want 800/001", s_min, s_max);
    end
    n_cmp++;
    if (u_min !== 12'h001 || u_max !== 12'hFFF) begin
      n_bad++;
      $display("FAIL unsigned_newmin got %h/%h want 001/fff", u_min, u_max);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_clear();
    do_reset();
    in_valid = 1'b1; a = 12'd20; b = 12'd0;
    cyc();
    a = 12'd3;
    cyc();
    n_cmp++;
    if (u_min !== 12'd3 || u_max !== 12'd20) begin
      n_bad++;
      $display("FAIL clear_pre got %0d/%0d want 3/20", u_min, u_max);
    end
    clear = 1'b1; a = 12'd7;
    cyc();
    n_cmp++;
    if (u_min !== 12'd7 || u_max !== 12'd7 || {u_ov, u_gt, u_seen} !== 3'b111) begin
      n_bad++;
      $display("FAIL clear_with_valid got %0d/%0d %b want 7/7 111",
               u_min, u_max, {u_ov, u_gt, u_seen});
    end
`ifdef CMP_COUNT_EN
    n_cmp++;
    if (u_count !== 3'd1) begin
      n_bad++;
      $display("FAIL clear_with_valid_count got %0d want 1", u_count);
    end
`endif
    in_valid = 1'b0;
    cyc();
    n_cmp++;
    if (u_min !== 12'd0 || u_max !== 12'd0 || {u_ov, u_sm, u_eq, u_gt, u_seen} !== 5'b00010) begin
      n_bad++;
      $display("FAIL clear_alone got %0d/%0d %b want 0/0 00010",
               u_min, u_max, {u_ov, u_sm, u_eq, u_gt, u_seen});
    end
`ifdef CMP_COUNT_EN
    n_cmp++;
    if (u_count !== 3'd0) begin
      n_bad++;
      $display("FAIL clear_alone_count got %0d want 0", u_count);
    end
`endif
    clear = 1'b0; in_valid = 1'b1; a = 12'd9; b = 12'd9;
    cyc();
    n_cmp++;
    if (u_min !== 12'd9 || u_max !== 12'd9 || {u_ov, u_eq, u_seen} !== 3'b111) begin
      n_bad++;
      $display("FAIL after_clear got %0d/%0d %b want 9/9 111",
               u_min, u_max, {u_ov, u_eq, u_seen});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_gaps();
    do_reset();
    in_valid = 1'b1; a = 12'd2; b = 12'd8;
    cyc();
    in_valid = 1'b0; a = 12'd900; b = 12'd1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if ({u_ov, u_sm, u_eq, u_gt} !== 4'b0100 || u_min !== 12'd2 || u_max !== 12'd2) begin
        n_bad++;
        $display("FAIL gap_hold[%0d] got %b %0d/%0d want 0100 2/2",
                 i, {u_ov, u_sm, u_eq, u_gt}, u_min, u_max);
      end
    end
  endtask

  task automatic test_reset_edges();
    do_reset();
    // Reset asserted while a sample is presented: nothing must survive.
    in_valid = 1'b1; a = 12'd5; b = 12'd1;
    @(negedge clk);
    reset_n = 1'b0;
    cyc();
    in_valid = 1'b0;
    reset_n  = 1'b1;
    cyc();
    n_cmp++;
    if ({u_ov, u_seen} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_discard got %b want 00", {u_ov, u_seen});
    end
    // First edge after release must accept.
    reset_n = 1'b0;
    cyc();
    reset_n  = 1'b1;
    in_valid = 1'b1; a = 12'd4; b = 12'd4;
    cyc();
    n_cmp++;
    if ({u_ov, u_eq, u_seen} !== 3'b111 || u_min !== 12'd4) begin
      n_bad++;
      $display("FAIL first_after_reset got %b %0d want 111 4", {u_ov, u_eq, u_seen}, u_min);
    end
    in_valid = 1'b0;
  endtask

`ifdef CMP_COUNT_EN
  task automatic test_count();
    do_reset();
    in_valid = 1'b1; a = 12'd1; b = 12'd1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i == 2) begin
        n_cmp++;
        if (u_count !== 3'd3) begin
          n_bad++;
          $display("FAIL count_3 got %0d want 3", u_count);
        end
      end
    end
    in_valid = 1'b0;
    cyc();
    n_cmp++;
    if (u_count !== 3'd7) begin
      n_bad++;
      $display("FAIL count_sat got %0d want 7", u_count);
    end
    n_cmp++;
    if (s_count !== 8'd10) begin
      n_bad++;
      $display("FAIL count_wide got %0d want 10", s_count);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_signed();
    test_clear();
    test_gaps();
    test_reset_edges();
`ifdef CMP_COUNT_EN
    test_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_comparator_nbit.md
SEQ_COMPARATOR_NBIT -- requirements
Module: seq_comparator_nbit

Interface
REQ-001 SHALL have parameter N, default 12, operand width in bits (N >= 2).
REQ-002 SHALL have parameter SIGNED, default 0; 0 = unsigned compare, 1 = two's-complement compare.
REQ-003 SHALL have parameter CNT_W, default 8, width of the sample counter.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port clear  input  1  synchronous clear of the running statistics.
REQ-007 SHALL have port in_valid  input  1  qualifies a and b for the current cycle.
REQ-008 SHALL have port a  input  N  first operand, also the tracked sample.
REQ-009 SHALL have port b  input  N  second operand.
REQ-010 SHALL have port out_valid  output  1  the compare flags hold a fresh result.
REQ-011 SHALL have ports smaller, equal, greater  output  1 each  registered a<b, a==b and a>b.
REQ-012 SHALL have ports min_val, max_val  output  N each  running minimum and maximum of accepted a.
REQ-013 SHALL have port seen  output  1  at least one sample accepted since reset or clear.

Function
REQ-014 SHALL accept a sample on each rising edge where in_valid=1; no backpressure exists.
REQ-015 SHALL assert out_valid for exactly one cycle, the cycle after acceptance (latency 1).
REQ-016 SHALL register smaller/equal/greater on acceptance, one-hot, and hold them until the next acceptance.
REQ-017 SHALL keep the flags unchanged while out_valid=0.
REQ-018 SHALL compare as unsigned when SIGNED=0 and as two's complement when SIGNED=1; e.g. N=12, a=12'hFFF, b=1 gives greater when SIGNED=0 and smaller when SIGNED=1.
REQ-019 SHALL load both min_val and max_val with a on the first acceptance after reset or clear, and set seen.
REQ-020 SHALL, on each later acceptance, replace min_val if a < min_val and max_val if a > max_val, using the same signedness as REQ-018.
REQ-021 SHALL leave min_val and max_val unchanged when a equals the current extreme.
REQ-022 SHALL, when clear=1 without in_valid, zero min_val and max_val, deassert seen, and leave the compare flags and out_valid behaviour unaffected.
REQ-023 SHALL, when clear=1 and in_valid=1 in the same cycle, treat the sample as the first after clear: min_val=max_val=a, seen=1, and flags updated as in REQ-016.
REQ-024 SHALL update min_val and max_val in the same cycle as the flags, so all are visible together while out_valid=1.

Reset
REQ-025 SHALL, while reset_n=0, drive out_valid=0, smaller=0, equal=0, greater=0, min_val=0, max_val=0, seen=0 (and count=0 when present), independent of clk.
REQ-026 SHALL discard any sample accepted in the edge that coincides with the reset assertion, and produce no out_valid pulse for it after release.
REQ-027 SHALL accept a sample on the first rising edge after reset_n deasserts.

Configuration
REQ-028 SHALL, with macro CMP_COUNT_EN defined, add output count (CNT_W bits) that counts acceptances.
REQ-029 SHALL make count saturate at 2^CNT_W-1 with no wrap-around.
REQ-030 SHALL make clear reset count to 0, or to 1 when clear and in_valid occur in the same cycle.
REQ-031 SHALL, without CMP_COUNT_EN, have no count port and no counter logic; all other behaviour is identical.

Verification
REQ-032 SHALL cover reset: reset_n=0 for 2 cycles, then release -> all outputs 0 and seen=0.
REQ-033 SHALL cover a stream with SIGNED=0, N=12, a/b pairs (5,99), (66,66), (100,47) on consecutive cycles -> one cycle later in each case: smaller, then equal, then greater; out_valid high for 3 cycles; final min_val=5, max_val=100.
REQ-034 SHALL cover SIGNED=1, N=12, a=12'hFFF and b=1 -> smaller=1; then a=12'h800 -> min_val=12'h800 and max_val=12'hFFF.
REQ-035 SHALL cover clear: clear and in_valid with a=7 in the same cycle after prior samples -> min_val=max_val=7, seen=1; clear alone -> min_val=max_val=0, seen=0.
REQ-036 SHALL cover counter saturation with CMP_COUNT_EN defined and CNT_W=3: 10 acceptances -> count=7.
REQ-037 SHALL cover gaps: in_valid=0 for 3 cycles between samples -> out_valid=0 and the flags held.
